// File: rtl/uart_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader_if
// Description : Run-mode read port and loader status bundle between the
//               program loader (slave) and the CPU fetch stage (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_prog_loader_if #(
    parameter int ADDR_W     = 8,
    parameter int WORD_BYTES = 2
);
    logic [ADDR_W-1:0]       rd_addr;
    logic [8*WORD_BYTES-1:0] rd_data;
    logic                    mode;
    logic [ADDR_W:0]         words_loaded;
    logic                    full;
    logic                    frame_err;
    logic                    busy;

    modport master (
        output rd_addr,
        input  rd_data, mode, words_loaded, full, frame_err, busy
    );

    modport slave (
        input  rd_addr,
        output rd_data, mode, words_loaded, full, frame_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader
// Description : 8N1 UART receiver that packs bytes little-endian into words
//               and loads them into program memory; button toggles load/run.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 234,
    parameter int WORD_BYTES   = 2,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_BITS = 32,
    parameter bit WRAP         = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          rx,
    input  wire logic          mode_btn,
    uart_prog_loader_if.slave  bus
);
    localparam int c_DATA_W   = 8 * WORD_BYTES;
    localparam int c_DEPTH    = 1 << ADDR_W;
    localparam int c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int c_TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int c_TO_W     = $clog2(c_TO_LIMIT + 1);

    localparam logic [c_CNT_W-1:0] c_HALF      = c_CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_LANE = c_IDX_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W:0]    c_DEPTH_CNT = (ADDR_W + 1)'(c_DEPTH);
    localparam logic [ADDR_W-1:0]  c_TOP       = ADDR_W'(c_DEPTH - 1);
    localparam logic [c_TO_W-1:0]  c_TO_END    = c_TO_W'(c_TO_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ---------------- input synchronisers ----------------
    logic r_rx_meta, r_rx_s, r_rx_prev;
    logic r_btn_meta, r_btn_s, r_btn_prev;
    logic w_toggle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_btn_meta <= 1'b1;
            r_btn_s    <= 1'b1;
            r_btn_prev <= 1'b1;
        end else begin
            r_rx_meta  <= rx;
            r_rx_s     <= r_rx_meta;
            r_rx_prev  <= r_rx_s;
            r_btn_meta <= mode_btn;
            r_btn_s    <= r_btn_meta;
            r_btn_prev <= r_btn_s;
        end
    end

    assign w_toggle = r_btn_prev & ~r_btn_s;

    // ---------------- receiver FSM ----------------
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_byte_ok;
    logic               r_byte_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_ok  <= 1'b0;
            r_byte_bad <= 1'b0;
        end else begin
            r_byte_ok  <= 1'b0;
            r_byte_bad <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (r_rx_prev && !r_rx_s)
                        r_state <= S_START;
                end
                S_START: begin
                    // Line back high at mid start bit: treat as noise.
                    if (r_cnt == c_HALF && r_rx_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_HALF)
                        r_shift <= {r_rx_s, r_shift[7:1]};
                    if (r_cnt == c_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7)
                            r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_HALF) begin
                        r_byte_ok  <= r_rx_s;
                        r_byte_bad <= ~r_rx_s;
                        r_state    <= S_IDLE;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- word assembly, memory control, mode ----------------
    logic [c_DATA_W-1:0] mem [c_DEPTH];
    logic                r_mode;
    logic [c_IDX_W-1:0]  r_byte_idx;
    logic [c_DATA_W-1:0] r_word;
    logic                r_wr_pend;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_words_loaded;
    logic                r_full;
    logic                r_frame_err;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [c_DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (r_wr_pend && !r_full)
            mem[r_wr_ptr] <= r_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode         <= 1'b0;
            r_byte_idx     <= '0;
            r_word         <= '0;
            r_wr_pend      <= 1'b0;
            r_wr_ptr       <= '0;
            r_words_loaded <= '0;
            r_full         <= 1'b0;
            r_frame_err    <= 1'b0;
            r_to_cnt       <= '0;
            r_rd_data      <= '0;
        end else begin
            r_wr_pend <= 1'b0;
            r_rd_data <= r_mode ? mem[bus.rd_addr] : '0;

            if (r_wr_pend && !r_full) begin
                if (r_words_loaded != c_DEPTH_CNT)
                    r_words_loaded <= r_words_loaded + (ADDR_W + 1)'(1);
                if (!WRAP && r_wr_ptr == c_TOP)
                    r_full <= 1'b1;
                else
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end

            // A partial word left idle too long is abandoned silently.
            if (r_byte_idx != '0 && r_state == S_IDLE) begin
                if (r_to_cnt == c_TO_END) begin
                    r_byte_idx <= '0;
                    r_to_cnt   <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + c_TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end

            if (!r_mode) begin
                if (r_byte_ok) begin
                    r_word[{r_byte_idx, 3'b000} +: 8] <= r_shift;
                    if (r_byte_idx == c_LAST_LANE) begin
                        r_byte_idx <= '0;
                        r_wr_pend  <= 1'b1;
                    end else begin
                        r_byte_idx <= r_byte_idx + c_IDX_W'(1);
                    end
                end else if (r_byte_bad) begin
                    r_frame_err <= 1'b1;
                    r_byte_idx  <= '0;
                end
            end

            if (w_toggle) begin
                r_mode <= ~r_mode;
                if (r_mode) begin
                    r_wr_ptr       <= '0;
                    r_byte_idx     <= '0;
                    r_words_loaded <= '0;
                    r_full         <= 1'b0;
                    r_frame_err    <= 1'b0;
                    r_to_cnt       <= '0;
                end
            end
        end
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.mode         = r_mode;
    assign bus.words_loaded = r_words_loaded;
    assign bus.full         = r_full;
    assign bus.frame_err    = r_frame_err;
    assign bus.busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire
